// File: rtl/interp_pixel_feeder.sv
// rtl/interp_pixel_feeder.sv - edge-padded line streamer feeding the sub-pixel interpolator (optional INTERP_FEED_BORDER_ZERO_EN)
module interp_pixel_feeder #(
    parameter int DATA_W   = 8,
    parameter int BLK      = 16,
    parameter int PAD_PRE  = 8,
    parameter int PAD_POST = 5,
    parameter int CAP_OFS  = 13
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [2*$clog2(BLK)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      start,
    input  logic                      col_mode,
    output logic [DATA_W-1:0]         data_out,
    output logic                      valid,
    input  logic                      ready,
    output logic                      cap_valid,
    output logic [$clog2(BLK)-1:0]    cap_line,
    output logic [$clog2(BLK)-1:0]    cap_pos,
    output logic                      busy,
    output logic                      done
);

    localparam int LINE_W = $clog2(BLK);
    localparam int BEATS  = BLK + PAD_PRE + PAD_POST;
    localparam int BEAT_W = $clog2(BEATS);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] PRE_END   = BEAT_W'(PAD_PRE);
    localparam logic [BEAT_W-1:0] DATA_END  = BEAT_W'(PAD_PRE + BLK);
    localparam logic [BEAT_W-1:0] CAP_START = BEAT_W'(CAP_OFS);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(BLK - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                mode_q, mode_d;
    logic [DATA_W-1:0]   mem_q [BLK*BLK];
    logic [DATA_W-1:0]   mem_d [BLK*BLK];

    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                valid_q, valid_d;
    logic                cap_valid_q, cap_valid_d;
    logic [LINE_W-1:0]   cap_line_q, cap_line_d;
    logic [LINE_W-1:0]   cap_pos_q, cap_pos_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [LINE_W-1:0]   pix_idx;
    logic [2*LINE_W-1:0] rd_addr;
    logic [DATA_W-1:0]   pix;
`ifdef INTERP_FEED_BORDER_ZERO_EN
    logic                border;
`endif

    // Block buffer: loads only while idle so a running pass always sees a frozen block.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (state_q == IDLE)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Pass sequencing: line/beat counters advance only when the interpolator takes a beat.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    mode_d  = col_mode;
                    line_d  = '0;
                    beat_d  = '0;
                end
            end
            STREAM: begin
                if (valid_q && ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (line_q == LAST_LINE) begin
                            state_d = DONE;
                            line_d  = '0;
                        end else begin
                            line_d = line_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output beat is built from the next counter values so every output leaves a flop;
    // a stalled beat simply recomputes the same values.
    always_comb begin
        if (beat_d < PRE_END) begin
            pix_idx = '0;
        end else if (beat_d < DATA_END) begin
            pix_idx = LINE_W'(beat_d - PRE_END);
        end else begin
            pix_idx = LAST_LINE;
        end
        // Row lines walk the column index, column lines walk the row index.
        rd_addr = mode_d ? {pix_idx, line_d} : {line_d, pix_idx};
        pix     = mem_d[rd_addr];
`ifdef INTERP_FEED_BORDER_ZERO_EN
        border = (beat_d < PRE_END) || (beat_d >= DATA_END);
        if (border) begin
            pix = '0;
        end
`endif
        data_out_d  = '0;
        valid_d     = 1'b0;
        cap_valid_d = 1'b0;
        cap_line_d  = '0;
        cap_pos_d   = '0;
        busy_d      = (state_d == STREAM);
        done_d      = (state_d == DONE);
        if (state_d == STREAM) begin
            data_out_d = pix;
            valid_d    = 1'b1;
            if (beat_d >= CAP_START) begin
                cap_valid_d = 1'b1;
                cap_pos_d   = LINE_W'(beat_d - CAP_START);
                cap_line_d  = line_d;
            end
        end
    end

    // State, buffer and registered outputs; reset aborts any pass and wipes the block.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            line_q      <= '0;
            beat_q      <= '0;
            mode_q      <= 1'b0;
            mem_q       <= '{default: '0};
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_line_q  <= '0;
            cap_pos_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            beat_q      <= beat_d;
            mode_q      <= mode_d;
            mem_q       <= mem_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            cap_valid_q <= cap_valid_d;
            cap_line_q  <= cap_line_d;
            cap_pos_q   <= cap_pos_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign cap_valid = cap_valid_q;
    assign cap_line  = cap_line_q;
    assign cap_pos   = cap_pos_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
